// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and term width for the MAC accumulator.
package mac_pkg;
    localparam int TERM_W = 9;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/sat_adder.sv
// sat_adder: adds a 9-bit unsigned term to a W-bit value, clamping to all-ones on carry-out.
module sat_adder
    import mac_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]      a_i,
    input  logic [TERM_W-1:0] b_i,
    output logic [W-1:0]      y_o,
    output logic              sat_o
);
    logic [W:0] sum_w;
    assign sum_w = {1'b0, a_i} + {{(W + 1 - TERM_W){1'b0}}, b_i};
    assign sat_o = sum_w[W];
    assign y_o   = sat_o ? '1 : sum_w[W-1:0];
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates len {carry,sum} terms with saturation, then holds the result
// until the downstream handshake completes.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       sum,
    input  logic             carry,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy
);
    state_t           state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q;
    logic             ovf_q, sat_d;

    sat_adder #(.W(ACC_W)) u_add (
        .a_i   (acc_q),
        .b_i   ({carry, sum}),
        .y_o   (acc_d),
        .sat_o (sat_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= ACCUM;
                    acc_q   <= '0;
                    ovf_q   <= 1'b0;
                    cnt_q   <= {len == 4'd0, len};
                end
                ACCUM: if (in_valid) begin
                    acc_q   <= acc_d;
                    ovf_q   <= ovf_q | sat_d;
                    cnt_q   <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) state_q <= HOLD;
                end
                HOLD: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == HOLD;
    assign busy      = state_q != IDLE;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
endmodule
